// File: rtl/spi3w_pkg.sv
`default_nettype none
// ==========================================================================
// spi3w_pkg : shared constants, state encoding and instruction builder
// Rev 1.0
// ==========================================================================
package spi3w_pkg;

  localparam int INSTR_BITS = 16;
  localparam int FRAME_BITS = 24;

  // Instruction field positions: [15] R/W, [14:13] byte count, [12:0] address
  localparam int RW_POS = 15;
  localparam int W_LSB  = 13;

  localparam logic       RW_READ    = 1'b1;
  localparam logic [1:0] W_ONE_BYTE = 2'b00;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  function automatic logic [INSTR_BITS-1:0] make_instr(input logic rw,
                                                       input logic [W_LSB-1:0] addr);
    logic [INSTR_BITS-1:0] instr;
    instr                    = '0;
    instr[RW_POS]            = rw;
    instr[RW_POS-1:W_LSB]    = W_ONE_BYTE;
    instr[W_LSB-1:0]         = addr;
    return instr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi3w_half_tick.sv
`default_nettype none
// ==========================================================================
// spi3w_half_tick : loadable down-counter, one-cycle tick every H cycles
// Rev 1.0
// ==========================================================================
module spi3w_half_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        run,
  input  logic [15:0] load_val,
  output logic        tick
);

  logic [15:0] cnt;
  logic [15:0] reload;

  // The reload value is captured on start so the divider cannot change mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      reload <= '0;
    end else if (start) begin
      cnt    <= load_val;
      reload <= load_val;
    end else if (run) begin
      if (cnt == '0) cnt <= reload;
      else           cnt <= cnt - 16'd1;
    end
  end

  assign tick = run && (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/spi3w_adc_master.sv
`default_nettype none
// ==========================================================================
// spi3w_adc_master : 3-wire SPI master, 16-bit instruction + data byte frame
// Rev 1.0
// ==========================================================================
module spi3w_adc_master
  import spi3w_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int FRAME_BITS = spi3w_pkg::FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       clk_div_cnt,
  input  logic              cmd_read,
  input  logic              cmd_write,
  output logic              cmd_read_ack,
  output logic              cmd_write_ack,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              spi_ce,
  output logic              spi_sclk,
  output logic              spi_dir,
  input  logic              spi_in,
  output logic              spi_out
);

  localparam logic [4:0] LAST_BIT   = 5'(FRAME_BITS - 1);
  localparam logic [4:0] LAST_INSTR = 5'(INSTR_BITS - 1);
  localparam logic [4:0] FIRST_DATA = 5'(INSTR_BITS);

  state_t                  state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [DATA_W-1:0]       rx;
  logic [4:0]              bit_cnt;
  logic                    is_read;
  logic                    sclk;
  logic                    dir;
  logic                    accept;
  logic                    run;
  logic                    tick;

  assign accept = (state == ST_IDLE) && (cmd_write || cmd_read);
  assign run    = (state != ST_IDLE) && (state != ST_DONE);

  spi3w_half_tick u_half_tick (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .run      (run),
    .load_val (clk_div_cnt),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
      sclk      <= 1'b0;
      dir       <= 1'b1;
      read_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          // Write has priority; a concurrent read stays pending until after the write ack.
          if (cmd_write) begin
            is_read <= 1'b0;
            shreg   <= {make_instr(~RW_READ, write_addr), write_data};
            state   <= ST_SETUP;
          end else if (cmd_read) begin
            is_read <= 1'b1;
            shreg   <= {make_instr(RW_READ, read_addr), {DATA_W{1'b0}}};
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
              if (is_read && (bit_cnt >= FIRST_DATA)) rx <= {rx[DATA_W-2:0], spi_in};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                state <= ST_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                // Turn the line around once the instruction has been clocked out.
                if (is_read && (bit_cnt == LAST_INSTR)) dir <= 1'b0;
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state <= ST_GAP;
            dir   <= 1'b1;
          end
        end
        ST_GAP: begin
          if (tick) begin
            state <= ST_DONE;
            if (is_read) read_data <= rx;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign spi_ce        = !((state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD));
  assign spi_sclk      = sclk;
  assign spi_dir       = dir;
  assign spi_out       = ((state == ST_SETUP) || (state == ST_SHIFT)) && dir && shreg[FRAME_BITS-1];
  assign cmd_write_ack = (state == ST_DONE) && !is_read;
  assign cmd_read_ack  = (state == ST_DONE) && is_read;

endmodule
`default_nettype wire

// File: tb/tb_spi3w_adc_master.sv
`default_nettype none
// ==========================================================================
// tb_spi3w_adc_master : self-checking bench with bus monitor and slave model
// Rev 1.0
// ==========================================================================
module tb_spi3w_adc_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] clk_div_cnt = 16'd1;
  logic        cmd_read = 1'b0;
  logic        cmd_write = 1'b0;
  logic        cmd_read_ack, cmd_write_ack;
  logic [12:0] read_addr = '0;
  logic [12:0] write_addr = '0;
  logic [7:0]  write_data = '0;
  logic [7:0]  read_data;
  logic        spi_ce, spi_sclk, spi_dir, spi_out;
  logic        spi_in = 1'b0;

  spi3w_adc_master dut (
    .clk           (clk),
    .rst           (rst),
    .clk_div_cnt   (clk_div_cnt),
    .cmd_read      (cmd_read),
    .cmd_write     (cmd_write),
    .cmd_read_ack  (cmd_read_ack),
    .cmd_write_ack (cmd_write_ack),
    .read_addr     (read_addr),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .read_data     (read_data),
    .spi_ce        (spi_ce),
    .spi_sclk      (spi_sclk),
    .spi_dir       (spi_dir),
    .spi_in        (spi_in),
    .spi_out       (spi_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Bus observation state, advanced once per clock by step()
  int          cyc, wack_n, rack_n, both_n, wack_cyc, rack_cyc;
  logic        prev_ce = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [23:0] m_word, m_dir;
  int          m_edges, m_celow, m_last_rise, m_pmin, m_pmax;
  logic [23:0] fr_word[$];
  logic [23:0] fr_dir[$];
  int          fr_edges[$], fr_celow[$], fr_pmin[$], fr_pmax[$];
  logic [7:0]  slave_byte = '0;
  logic [7:0]  rd_at_ack, rd_before, last_read;
  int          idle_ce_low;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (cmd_write_ack) begin wack_n++; wack_cyc = cyc; end
    if (cmd_read_ack)  begin rack_n++; rack_cyc = cyc; end
    if (cmd_write_ack && cmd_read_ack) both_n++;
    if (prev_ce && !spi_ce) begin
      m_word = '0; m_dir = '0; m_edges = 0; m_celow = 0; m_pmin = 1000000; m_pmax = 0;
    end
    if (!spi_ce) m_celow++;
    if (!prev_sclk && spi_sclk) begin
      if (m_edges > 0) begin
        if (cyc - m_last_rise < m_pmin) m_pmin = cyc - m_last_rise;
        if (cyc - m_last_rise > m_pmax) m_pmax = cyc - m_last_rise;
      end
      m_last_rise = cyc;
      m_word = {m_word[22:0], spi_out};
      m_dir  = {m_dir[22:0], spi_dir};
      m_edges++;
    end
    if (!prev_ce && spi_ce) begin
      fr_word.push_back(m_word); fr_dir.push_back(m_dir); fr_edges.push_back(m_edges);
      fr_celow.push_back(m_celow); fr_pmin.push_back(m_pmin); fr_pmax.push_back(m_pmax);
    end
    prev_ce   = spi_ce;
    prev_sclk = spi_sclk;
    // Slave: once the line is released, present the byte MSB first ahead of rising edges 17..24
    if (!spi_dir && m_edges >= 16 && m_edges < 24) spi_in = slave_byte[7 - (m_edges - 16)];
    else spi_in = 1'b0;
  endtask

  task automatic clear_obs();
    fr_word.delete(); fr_dir.delete(); fr_edges.delete();
    fr_celow.delete(); fr_pmin.delete(); fr_pmax.delete();
    wack_n = 0; rack_n = 0; both_n = 0; wack_cyc = -1; rack_cyc = -1;
  endtask

  // Issues one request, scrambles the inputs after acceptance, holds the request through
  // the ack cycle plus one, then watches a few idle cycles.
  task automatic run_frame(input bit is_read, input logic [12:0] addr,
                           input logic [7:0] data, input logic [7:0] sbyte, input int h);
    clk_div_cnt = 16'(h - 1);
    slave_byte  = sbyte;
    rd_before   = read_data;
    rd_at_ack   = 8'hxx;
    clear_obs();
    if (is_read) begin read_addr = addr; cmd_read = 1'b1; end
    else begin write_addr = addr; write_data = data; cmd_write = 1'b1; end
    cyc = -1;
    for (int i = 0; i < 51 * h + 8; i++) begin
      step();
      if (cyc == 2) begin
        write_addr  = 13'($urandom);
        write_data  = 8'($urandom);
        read_addr   = 13'($urandom);
        clk_div_cnt = 16'($urandom_range(0, 7));
      end
      if (cmd_write_ack || cmd_read_ack) begin rd_at_ack = read_data; break; end
    end
    idle_ce_low = 0;
    step();
    if (!spi_ce) idle_ce_low++;
    cmd_read = 1'b0; cmd_write = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); if (!spi_ce) idle_ce_low++; end
  endtask

  function automatic logic [23:0] exp_frame(input bit is_read, input logic [12:0] addr,
                                            input logic [7:0] data);
    return (is_read ? 24'h800000 : 24'h000000) + (24'(addr) << 8) + (is_read ? 24'h0 : 24'(data));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_chk++;
    if ({spi_ce, spi_sclk, spi_dir, spi_out, cmd_read_ack, cmd_write_ack} !== 6'b101000) begin
      n_fail++;
      $display("FAIL reset_outputs: got ce/sclk/dir/out/rack/wack=%b want 101000",
               {spi_ce, spi_sclk, spi_dir, spi_out, cmd_read_ack, cmd_write_ack});
    end
    n_chk++;
    if (read_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_read_data: got %h want 00", read_data);
    end
    rst = 1'b0;
    repeat (2) step();
    n_chk++;
    if ({spi_ce, spi_sclk, spi_dir, spi_out} !== 4'b1010) begin
      n_fail++; $display("FAIL idle_outputs: got %b want 1010", {spi_ce, spi_sclk, spi_dir, spi_out});
    end
    last_read = 8'h00;
  endtask

  task automatic test_write();
    run_frame(1'b0, 13'h0018, 8'h3C, 8'h00, 2);
    n_chk++;
    if (wack_cyc !== 102 || wack_n !== 1 || rack_n !== 0) begin
      n_fail++; $display("FAIL write_ack: got cycle %0d wack %0d rack %0d want 102/1/0", wack_cyc, wack_n, rack_n);
    end
    n_chk++;
    if (fr_word.size() != 1 || fr_word[0] !== 24'h00183C) begin
      n_fail++; $display("FAIL write_frame: got %0d frames first %h want 1 frame 00183c",
                         fr_word.size(), (fr_word.size() > 0) ? fr_word[0] : 24'hx);
    end
    n_chk++;
    if (fr_dir.size() != 1 || fr_dir[0] !== 24'hFFFFFF) begin
      n_fail++; $display("FAIL write_dir: got %h want ffffff", (fr_dir.size() > 0) ? fr_dir[0] : 24'hx);
    end
    n_chk++;
    if (fr_edges.size() != 1 || fr_edges[0] != 24 || fr_celow[0] != 100 || fr_pmin[0] != 4 || fr_pmax[0] != 4) begin
      n_fail++; $display("FAIL write_timing: got edges/celow/pmin/pmax %0d/%0d/%0d/%0d want 24/100/4/4",
                         m_edges, m_celow, m_pmin, m_pmax);
    end
    n_chk++;
    if (read_data !== rd_before) begin
      n_fail++; $display("FAIL write_keeps_read_data: got %h want %h", read_data, rd_before);
    end
  endtask

  task automatic test_read();
    run_frame(1'b1, 13'h001F, 8'h00, 8'hA5, 2);
    n_chk++;
    if (rack_cyc !== 102 || rack_n !== 1 || wack_n !== 0) begin
      n_fail++; $display("FAIL read_ack: got cycle %0d rack %0d wack %0d want 102/1/0", rack_cyc, rack_n, wack_n);
    end
    n_chk++;
    if (fr_word.size() != 1 || fr_word[0] !== 24'h801F00) begin
      n_fail++; $display("FAIL read_frame: got %0d frames first %h want 801f00",
                         fr_word.size(), (fr_word.size() > 0) ? fr_word[0] : 24'hx);
    end
    n_chk++;
    if (fr_dir.size() != 1 || fr_dir[0] !== 24'hFFFF00) begin
      n_fail++; $display("FAIL read_dir: got %h want ffff00", (fr_dir.size() > 0) ? fr_dir[0] : 24'hx);
    end
    n_chk++;
    if (rd_at_ack !== 8'hA5 || read_data !== 8'hA5) begin
      n_fail++; $display("FAIL read_data: got at-ack %h after %h want a5", rd_at_ack, read_data);
    end
    n_chk++;
    if (spi_dir !== 1'b1) begin
      n_fail++; $display("FAIL read_dir_restored: got %b want 1", spi_dir);
    end
    last_read = 8'hA5;
  endtask

  task automatic test_min_div();
    run_frame(1'b1, 13'($urandom), 8'h00, 8'h5A, 1);
    n_chk++;
    if (rack_cyc !== 51 || rd_at_ack !== 8'h5A) begin
      n_fail++; $display("FAIL min_div_read: got ack cycle %0d data %h want 51 5a", rack_cyc, rd_at_ack);
    end
    n_chk++;
    if (fr_pmin.size() != 1 || fr_pmin[0] != 2 || fr_pmax[0] != 2 || fr_edges[0] != 24) begin
      n_fail++; $display("FAIL min_div_sclk: got period %0d..%0d edges %0d want 2..2 24", m_pmin, m_pmax, m_edges);
    end
    last_read = 8'h5A;
  endtask

  task automatic test_held();
    run_frame(1'b0, 13'($urandom), 8'($urandom), 8'h00, 1 + $urandom_range(0, 2));
    n_chk++;
    if (wack_n !== 1 || rack_n !== 0 || fr_word.size() != 1 || idle_ce_low != 0) begin
      n_fail++; $display("FAIL held_request: got acks %0d/%0d frames %0d idle ce-low %0d want 1/0 1 0",
                         wack_n, rack_n, fr_word.size(), idle_ce_low);
    end
  endtask

  task automatic test_simultaneous();
    int          h;
    logic [12:0] wa, ra;
    logic [7:0]  wd, sb;
    h = 1 + $urandom_range(0, 1);
    wa = 13'($urandom); ra = 13'($urandom); wd = 8'($urandom); sb = 8'($urandom);
    clear_obs();
    clk_div_cnt = 16'(h - 1); slave_byte = sb;
    write_addr = wa; write_data = wd; read_addr = ra;
    cmd_write = 1'b1; cmd_read = 1'b1;
    cyc = -1;
    for (int i = 0; i < 102 * h + 30; i++) begin
      step();
      if (cmd_write_ack) cmd_write = 1'b0;
      if (cmd_read_ack) begin cmd_read = 1'b0; break; end
    end
    cmd_write = 1'b0; cmd_read = 1'b0;
    repeat (3) step();
    n_chk++;
    if (wack_n != 1 || rack_n != 1 || both_n != 0) begin
      n_fail++; $display("FAIL simul_acks: got wack %0d rack %0d both %0d want 1 1 0", wack_n, rack_n, both_n);
    end
    n_chk++;
    if (wack_cyc != 51 * h || rack_cyc != 102 * h + 2) begin
      n_fail++; $display("FAIL simul_order: got wack@%0d rack@%0d want %0d %0d", wack_cyc, rack_cyc, 51 * h, 102 * h + 2);
    end
    n_chk++;
    if (fr_word.size() != 2 || fr_word[0] !== exp_frame(1'b0, wa, wd) || fr_word[1] !== exp_frame(1'b1, ra, 8'h00)) begin
      n_fail++; $display("FAIL simul_frames: got %0d frames %h %h want %h %h", fr_word.size(),
                         (fr_word.size() > 0) ? fr_word[0] : 24'hx, (fr_word.size() > 1) ? fr_word[1] : 24'hx,
                         exp_frame(1'b0, wa, wd), exp_frame(1'b1, ra, 8'h00));
    end
    n_chk++;
    if (read_data !== sb) begin
      n_fail++; $display("FAIL simul_read_data: got %h want %h", read_data, sb);
    end
    last_read = sb;
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      bit          rd;
      int          h;
      logic [12:0] a;
      logic [7:0]  d, sb;
      rd = 1'($urandom); h = 1 + $urandom_range(0, 3);
      a = 13'($urandom); d = 8'($urandom); sb = 8'($urandom);
      run_frame(rd, a, d, sb, h);
      if (rd) last_read = sb;
      n_chk++;
      if ((rd ? rack_cyc : wack_cyc) != 51 * h || wack_n + rack_n != 1 || idle_ce_low != 0) begin
        n_fail++; $display("FAIL rand%0d_ack: got cycle %0d acks %0d want %0d 1", k,
                           rd ? rack_cyc : wack_cyc, wack_n + rack_n, 51 * h);
      end
      n_chk++;
      if (fr_word.size() != 1 || fr_word[0] !== exp_frame(rd, a, d) ||
          fr_dir[0] !== (rd ? 24'hFFFF00 : 24'hFFFFFF)) begin
        n_fail++; $display("FAIL rand%0d_frame: got %h dir %h want %h", k,
                           (fr_word.size() > 0) ? fr_word[0] : 24'hx, (fr_dir.size() > 0) ? fr_dir[0] : 24'hx,
                           exp_frame(rd, a, d));
      end
      n_chk++;
      if (fr_celow.size() != 1 || fr_celow[0] != 50 * h || fr_pmin[0] != 2 * h || fr_pmax[0] != 2 * h) begin
        n_fail++; $display("FAIL rand%0d_timing: got celow %0d period %0d..%0d want %0d %0d", k,
                           m_celow, m_pmin, m_pmax, 50 * h, 2 * h);
      end
      n_chk++;
      if (read_data !== last_read) begin
        n_fail++; $display("FAIL rand%0d_read_data: got %h want %h", k, read_data, last_read);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit reached;
    clear_obs();
    clk_div_cnt = 16'd1;
    write_addr = 13'($urandom); write_data = 8'($urandom);
    cmd_write = 1'b1;
    cyc = -1; reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (m_edges == 10 && !spi_ce) begin reached = 1'b1; break; end
    end
    rst = 1'b1; cmd_write = 1'b0;
    step();
    n_chk++;
    if (!reached || {spi_ce, spi_sclk, spi_dir} !== 3'b101) begin
      n_fail++; $display("FAIL reset_mid_outputs: got reached %b ce/sclk/dir %b want 1 101",
                         reached, {spi_ce, spi_sclk, spi_dir});
    end
    rst = 1'b0;
    repeat (120) step();
    n_chk++;
    if (wack_n != 0 || rack_n != 0) begin
      n_fail++; $display("FAIL reset_mid_no_ack: got wack %0d rack %0d want 0 0", wack_n, rack_n);
    end
    run_frame(1'b0, 13'h0ABC, 8'h96, 8'h00, 2);
    n_chk++;
    if (wack_cyc != 102 || fr_word.size() != 1 || fr_word[0] !== 24'h0ABC96) begin
      n_fail++; $display("FAIL reset_mid_recover: got ack@%0d frame %h want 102 0abc96",
                         wack_cyc, (fr_word.size() > 0) ? fr_word[0] : 24'hx);
    end
    n_chk++;
    if (read_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_read_data: got %h want 00", read_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_min_div();
    test_held();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/spi3w_adc_master.md
Name: spi3w_adc_master

Overview:
- 3-wire SPI master: the bit-level engine directly downstream of the ADC/PLL register-configuration sequencer.
- Accepts single-register read/write requests over a req/ack handshake and serialises a 24-bit frame: 16-bit instruction + 8-bit data, MSB first.
- Drives a shared bidirectional data line through spi_out/spi_dir and samples spi_in during read data.
- Returns read data with a one-cycle ack.

Parameters:
- ADDR_W, 13, register address width (instruction bits 12:0).
- DATA_W, 8, data byte width.
- FRAME_BITS, 24, total SCLK cycles per frame (16 + DATA_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_div_cnt  in  16  SCLK half-period minus 1, in clk cycles. H = clk_div_cnt + 1, latched at frame start.
- cmd_read  in  1  read request; held high until cmd_read_ack.
- cmd_write  in  1  write request; held high until cmd_write_ack.
- cmd_read_ack  out  1  one-cycle pulse: read frame complete, read_data valid.
- cmd_write_ack  out  1  one-cycle pulse: write frame complete.
- read_addr  in  13  read register address.
- write_addr  in  13  write register address.
- write_data  in  8  byte to write.
- read_data  out  8  last read byte; held until the next read completes.
- spi_ce  out  1  chip select, active low.
- spi_sclk  out  1  serial clock, idle low.
- spi_dir  out  1  1 = FPGA drives data line; 0 = released for slave.
- spi_in  in  1  data line input.
- spi_out  out  1  data line output.

Behaviour:
- Reset, and idle outputs:
  - spi_ce=1, spi_sclk=0, spi_dir=1, spi_out=0.
  - Both acks 0, read_data=0, FSM in IDLE.
  - rst is honoured on any edge, including mid-frame: the frame aborts and no ack is issued.
- Instruction word:
  - Bit 15 = R/W (1 = read).
  - Bits 14:13 = 00 (one byte).
  - Bits 12:0 = address.
- Frame assembly:
  - Shift register = {instr, write_data}, with the data byte = 0 for reads.
  - Address, data and H are latched at acceptance; later input changes are ignored.
- Request sampling:
  - cmd_* is sampled only in IDLE.
  - If cmd_write and cmd_read are both high, the write wins. The read stays pending and is served after the write ack.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> DONE -> IDLE.
  - SETUP: H cycles. ce=0, sclk=0, spi_out = bit 23.
  - SHIFT: 24 bit periods, each H cycles sclk low then H cycles sclk high. Rising edges occur at low->high.
    - Next bit is presented on spi_out at each high->low transition.
    - Read, bits 0-15: the FPGA drives.
    - Read, data phase: spi_dir drops to 0 at the falling sclk after the 16th rising edge; spi_out is then 0.
    - Read, sampling: spi_in is sampled into the receive shift register on the clk edge that raises sclk, for rising edges 17-24.
  - HOLD: H cycles. sclk=0, ce=0.
  - GAP: H cycles. ce=1, spi_dir=1.
  - DONE: 1 cycle. The matching ack is high. For reads, read_data is updated in this same cycle. The next state is IDLE unconditionally. This is why a request still high during the ack cycle never retriggers.
- Latency: with the acceptance edge = cycle 0, SETUP starts at cycle 0 and ack is high during cycle 51·H. Minimum spacing between back-to-back frames is 51·H + 2 cycles.
- Write frames never modify read_data.
- Counters:
  - Half-period counter is 16-bit and reloads to clk_div_cnt at each phase boundary.
  - Bit counter is 5-bit, 0..23.
  - No wrap beyond 23.

Decomposition:
- Package spi3w_pkg holds:
  - FSM state enum.
  - RW_READ=1'b1.
  - W_ONE_BYTE=2'b00.
  - INSTR_BITS=16.
  - Instruction bit-position constants.
  - FRAME_BITS.
- Sub-module spi3w_half_tick: a loadable down-counter emitting a one-cycle tick every H cycles. It is restarted on frame acceptance.

Test Plan:
- Write: clk_div_cnt=1, write_addr=0x0018, write_data=0x3C.
  - spi_out shifts 0x00183C MSB-first on rising edges.
  - spi_dir=1 throughout.
  - cmd_write_ack is a single pulse at cycle 102.
  - read_data unchanged.
- Read: read_addr=0x001F, slave model returns 0xA5.
  - Instruction 0x801F is observed.
  - spi_dir=0 from the falling edge after rising edge 16 until GAP.
  - read_data=0xA5 when cmd_read_ack pulses.
- Simultaneous requests: cmd_read and cmd_write both high.
  - Write frame first, then read frame.
  - Exactly one ack of each, never both in one cycle.
- Held request: requester drops cmd one cycle after ack.
  - Exactly one frame.
  - ce stays high through the following IDLE.
- Minimum divider: clk_div_cnt=0.
  - sclk period is 2 clk.
  - Ack at cycle 51.
  - A read of 0x5A is captured correctly.
- Reset mid-frame: rst at rising edge 10.
  - Next edge: ce=1, sclk=0, dir=1.
  - No ack.
  - A subsequent write completes normally.
